// File: rtl/dbus_pkg.sv
// Shared data-bus decode constants: region tags, peripheral register offsets, CTRL bits.
package dbus_pkg;

  typedef enum logic [1:0] {
    RGN_RAM    = 2'd0,
    RGN_PERIPH = 2'd1,
    RGN_NONE   = 2'd2
  } region_e;

  localparam logic [7:0] OFF_MTIME_LO    = 8'h00;
  localparam logic [7:0] OFF_MTIME_HI    = 8'h04;
  localparam logic [7:0] OFF_MTIMECMP_LO = 8'h08;
  localparam logic [7:0] OFF_MTIMECMP_HI = 8'h0C;
  localparam logic [7:0] OFF_CTRL        = 8'h10;
  localparam logic [7:0] OFF_TOHOST      = 8'h14;

  localparam int CTRL_EN_BIT = 0;

  function automatic logic periph_mapped(input logic [7:0] off);
    return (off == OFF_MTIME_LO)    || (off == OFF_MTIME_HI) ||
           (off == OFF_MTIMECMP_LO) || (off == OFF_MTIMECMP_HI) ||
           (off == OFF_CTRL)        || (off == OFF_TOHOST);
  endfunction

endpackage

// File: rtl/dbus_slave_mtimer.sv
// 64-bit machine timer with compare; loads take priority over the increment.
// irq is registered from the current mtime/mtimecmp values, so it lags the match by one edge.
module mtimer (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        en,
  input  logic        ld_lo,
  input  logic        ld_hi,
  input  logic        ld_cmp_lo,
  input  logic        ld_cmp_hi,
  input  logic [31:0] wdata,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        irq
);

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      mtime    <= 64'h0;
      mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      irq      <= 1'b0;
    end else begin
      // A load of either half suppresses that cycle's increment.
      if (ld_lo)
        mtime[31:0] <= wdata;
      else if (ld_hi)
        mtime[63:32] <= wdata;
      else if (en)
        mtime <= mtime + 64'd1;
      if (ld_cmp_lo) mtimecmp[31:0]  <= wdata;
      if (ld_cmp_hi) mtimecmp[63:32] <= wdata;
      irq <= en && (mtime >= mtimecmp);
    end
  end

endmodule

// File: rtl/dbus_slave.sv
// Data-bus responder: word RAM plus timer/tohost peripheral window.
// Reads are combinational, writes commit on the rising edge; no back-pressure.
module dbus_slave
  import dbus_pkg::*;
#(
  parameter int          RAM_DEPTH   = 1024,
  parameter logic [31:0] PERIPH_BASE = 32'h1000_0000
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        ram_ce_in,
  input  logic        ram_we_in,
  input  logic [31:0] ram_addr_in,
  input  logic [31:0] ram_wdata_in,
  output logic [31:0] ram_rdata_out,
  output logic        timer_irq_out,
  output logic        halt_out,
  output logic        bad_access_out
);

  localparam int AW = $clog2(RAM_DEPTH);

  logic [31:0]   mem [RAM_DEPTH];
  logic [AW-1:0] idx;
  logic [7:0]    off;
  region_e       region;
  logic          wr, rd, pw;
  logic          ctrl_en;
  logic [31:0]   tohost;
  logic [63:0]   mtime, mtimecmp;
  logic          unused_addr;

  assign idx = ram_addr_in[AW+1:2];
  assign off = {ram_addr_in[7:2], 2'b00};
  assign wr  = ram_ce_in & ram_we_in;
  assign rd  = ram_ce_in & ~ram_we_in;
  assign pw  = wr && (region == RGN_PERIPH);
  assign unused_addr = ^{ram_addr_in[27:AW+2], ram_addr_in[1:0]};

  always_comb begin
    region = RGN_NONE;
    if (ram_addr_in[31:28] == 4'h0)
      region = RGN_RAM;
    else if (ram_addr_in[31:28] == PERIPH_BASE[31:28] && periph_mapped(off))
      region = RGN_PERIPH;
  end

  mtimer u_mtimer (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .en        (ctrl_en),
    .ld_lo     (pw && off == OFF_MTIME_LO),
    .ld_hi     (pw && off == OFF_MTIME_HI),
    .ld_cmp_lo (pw && off == OFF_MTIMECMP_LO),
    .ld_cmp_hi (pw && off == OFF_MTIMECMP_HI),
    .wdata     (ram_wdata_in),
    .mtime     (mtime),
    .mtimecmp  (mtimecmp),
    .irq       (timer_irq_out)
  );

  // RAM is not reset, but a write landing while reset is held must be dropped.
  always_ff @(posedge clk_in) begin
    if (reset_in && wr && region == RGN_RAM)
      mem[idx] <= ram_wdata_in;
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      ctrl_en        <= 1'b0;
      tohost         <= 32'h0;
      halt_out       <= 1'b0;
      bad_access_out <= 1'b0;
    end else begin
      if (pw && off == OFF_CTRL)
        ctrl_en <= ram_wdata_in[CTRL_EN_BIT];
      if (pw && off == OFF_TOHOST && tohost == 32'h0 && ram_wdata_in != 32'h0) begin
        tohost   <= ram_wdata_in;
        halt_out <= 1'b1;
      end
      if (ram_ce_in && region == RGN_NONE)
        bad_access_out <= 1'b1;
    end
  end

  always_comb begin
    ram_rdata_out = 32'h0;
    if (rd) begin
      case (region)
        RGN_RAM: ram_rdata_out = mem[idx];
        RGN_PERIPH: begin
          case (off)
            OFF_MTIME_LO:    ram_rdata_out = mtime[31:0];
            OFF_MTIME_HI:    ram_rdata_out = mtime[63:32];
            OFF_MTIMECMP_LO: ram_rdata_out = mtimecmp[31:0];
            OFF_MTIMECMP_HI: ram_rdata_out = mtimecmp[63:32];
            OFF_CTRL:        ram_rdata_out = 32'(ctrl_en);
            OFF_TOHOST:      ram_rdata_out = tohost;
            default:         ram_rdata_out = 32'h0;
          endcase
        end
        default: ram_rdata_out = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_slave.sv
// Directed vector bench for dbus_slave: table for RAM/tohost/decode, hand sequences for timer and reset.
module tb_dbus_slave;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b0;
  logic        ram_ce_in = 1'b0;
  logic        ram_we_in = 1'b0;
  logic [31:0] ram_addr_in = 32'h0;
  logic [31:0] ram_wdata_in = 32'h0;
  logic [31:0] ram_rdata_out;
  logic        timer_irq_out;
  logic        halt_out;
  logic        bad_access_out;

  dbus_slave #(.RAM_DEPTH(1024), .PERIPH_BASE(32'h1000_0000)) dut (
    .clk_in         (clk_in),
    .reset_in       (reset_in),
    .ram_ce_in      (ram_ce_in),
    .ram_we_in      (ram_we_in),
    .ram_addr_in    (ram_addr_in),
    .ram_wdata_in   (ram_wdata_in),
    .ram_rdata_out  (ram_rdata_out),
    .timer_irq_out  (timer_irq_out),
    .halt_out       (halt_out),
    .bad_access_out (bad_access_out)
  );

  always #5 clk_in = ~clk_in;

  localparam logic [31:0] A_MTIME_LO = 32'h1000_0000;
  localparam logic [31:0] A_MTIME_HI = 32'h1000_0004;
  localparam logic [31:0] A_CMP_LO   = 32'h1000_0008;
  localparam logic [31:0] A_CMP_HI   = 32'h1000_000C;
  localparam logic [31:0] A_CTRL     = 32'h1000_0010;
  localparam logic [31:0] A_TOHOST   = 32'h1000_0014;

  typedef struct {
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_irq;
    logic        exp_halt;
    logic        exp_bad;
  } vec_t;

  int nvec = 0;
  int nerr = 0;
  vec_t vecs [23];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    ram_ce_in = 1'b1; ram_we_in = 1'b1; ram_addr_in = a; ram_wdata_in = d;
    @(posedge clk_in); #1;
    ram_ce_in = 1'b0; ram_we_in = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    ram_ce_in = 1'b1; ram_we_in = 1'b0; ram_addr_in = a;
    #1;
    chk(name, {32'h0, ram_rdata_out}, {32'h0, exp});
    ram_ce_in = 1'b0;
  endtask

  function automatic vec_t mk(input logic ce, input logic we, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] er,
                              input logic ei, input logic eh, input logic eb);
    vec_t v;
    v.ce = ce; v.we = we; v.addr = a; v.wdata = d;
    v.exp_rdata = er; v.exp_irq = ei; v.exp_halt = eh; v.exp_bad = eb;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Expected flags are the state before this vector's own edge.
    vecs[0]  = mk(0, 0, 32'h0000_0040, 32'h0,         32'h0,         0, 0, 0);
    vecs[1]  = mk(1, 1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0,         0, 0, 0);
    vecs[2]  = mk(1, 0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 0, 0, 0);
    vecs[3]  = mk(1, 0, 32'h0000_1040, 32'h0,         32'hDEAD_BEEF, 0, 0, 0);
    vecs[4]  = mk(1, 1, 32'h0000_0044, 32'h1234_5678, 32'h0,         0, 0, 0);
    vecs[5]  = mk(1, 0, 32'h0000_0044, 32'h0,         32'h1234_5678, 0, 0, 0);
    vecs[6]  = mk(1, 0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 0, 0, 0);
    vecs[7]  = mk(1, 0, A_TOHOST,      32'h0,         32'h0,         0, 0, 0);
    vecs[8]  = mk(1, 1, A_TOHOST,      32'h0,         32'h0,         0, 0, 0);
    vecs[9]  = mk(1, 0, A_TOHOST,      32'h0,         32'h0,         0, 0, 0);
    vecs[10] = mk(1, 1, A_TOHOST,      32'h1,         32'h0,         0, 0, 0);
    vecs[11] = mk(1, 0, A_TOHOST,      32'h0,         32'h1,         0, 1, 0);
    vecs[12] = mk(1, 1, A_TOHOST,      32'h5,         32'h0,         0, 1, 0);
    vecs[13] = mk(1, 0, A_TOHOST,      32'h0,         32'h1,         0, 1, 0);
    vecs[14] = mk(1, 0, A_CTRL,        32'h0,         32'h0,         0, 1, 0);
    vecs[15] = mk(1, 0, A_CMP_LO,      32'h0,         32'hFFFF_FFFF, 0, 1, 0);
    vecs[16] = mk(1, 0, A_CMP_HI,      32'h0,         32'hFFFF_FFFF, 0, 1, 0);
    vecs[17] = mk(1, 0, A_MTIME_LO,    32'h0,         32'h0,         0, 1, 0);
    vecs[18] = mk(0, 0, 32'h2000_0000, 32'h0,         32'h0,         0, 1, 0);
    vecs[19] = mk(1, 0, 32'h2000_0000, 32'h0,         32'h0,         0, 1, 0);
    vecs[20] = mk(0, 0, 32'h0,         32'h0,         32'h0,         0, 1, 1);
    vecs[21] = mk(0, 1, 32'h0000_0040, 32'h1111_1111, 32'h0,         0, 1, 1);
    vecs[22] = mk(1, 0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 0, 1, 1);

    #12 reset_in = 1'b1;
    @(posedge clk_in); #1;

    for (int i = 0; i < 23; i++) begin
      ram_ce_in = vecs[i].ce; ram_we_in = vecs[i].we;
      ram_addr_in = vecs[i].addr; ram_wdata_in = vecs[i].wdata;
      @(negedge clk_in);
      chk($sformatf("vec%0d {rdata,irq,halt,bad}", i),
          {29'h0, ram_rdata_out, timer_irq_out, halt_out, bad_access_out},
          {29'h0, vecs[i].exp_rdata, vecs[i].exp_irq, vecs[i].exp_halt, vecs[i].exp_bad});
      @(posedge clk_in); #1;
    end
    ram_ce_in = 1'b0; ram_we_in = 1'b0;

    // Compare match: enable edge is E0, irq rises after E11.
    wr(A_CMP_LO, 32'd10);
    wr(A_CMP_HI, 32'd0);
    wr(A_CTRL, 32'd1);
    repeat (10) @(posedge clk_in);
    #1 chk("irq_low_after_e10", {63'h0, timer_irq_out}, 64'h0);
    @(posedge clk_in); #1;
    chk("irq_high_after_e11", {63'h0, timer_irq_out}, 64'h1);
    rd_chk("mtime_lo_11", A_MTIME_LO, 32'd11);
    wr(A_CMP_LO, 32'd100);
    chk("irq_still_high_at_cmp_write", {63'h0, timer_irq_out}, 64'h1);
    @(posedge clk_in); #1;
    chk("irq_low_after_cmp_write", {63'h0, timer_irq_out}, 64'h0);

    // Wrap from all ones.
    wr(A_CTRL, 32'd0);
    wr(A_MTIME_LO, 32'hFFFF_FFFF);
    wr(A_MTIME_HI, 32'hFFFF_FFFF);
    rd_chk("mtime_lo_loaded", A_MTIME_LO, 32'hFFFF_FFFF);
    rd_chk("mtime_hi_loaded", A_MTIME_HI, 32'hFFFF_FFFF);
    wr(A_CTRL, 32'd1);
    rd_chk("mtime_lo_at_enable", A_MTIME_LO, 32'hFFFF_FFFF);
    @(posedge clk_in); #1;
    rd_chk("mtime_lo_wrapped", A_MTIME_LO, 32'h0);
    @(posedge clk_in); #1;
    rd_chk("mtime_hi_wrapped", A_MTIME_HI, 32'h0);

    // Asynchronous reset with irq, halt and bad all set.
    wr(A_CMP_LO, 32'd0);
    @(posedge clk_in); #1;
    chk("irq_before_reset", {61'h0, timer_irq_out, halt_out, bad_access_out}, 64'h7);
    #2;
    ram_ce_in = 1'b1; ram_we_in = 1'b0; ram_addr_in = A_MTIME_LO;
    reset_in = 1'b0;
    #1;
    chk("async_reset {rdata,irq,halt,bad}",
        {29'h0, ram_rdata_out, timer_irq_out, halt_out, bad_access_out}, 64'h0);
    ram_addr_in = A_CMP_LO;
    #1 chk("cmp_lo_in_reset", {32'h0, ram_rdata_out}, 64'hFFFF_FFFF);
    ram_we_in = 1'b1; ram_addr_in = A_TOHOST; ram_wdata_in = 32'd7;
    @(posedge clk_in); #2;
    ram_ce_in = 1'b0; ram_we_in = 1'b0;
    reset_in = 1'b1;
    #1 chk("halt_after_write_in_reset", {63'h0, halt_out}, 64'h0);
    rd_chk("tohost_after_write_in_reset", A_TOHOST, 32'h0);
    rd_chk("ram_kept_over_reset", 32'h0000_0040, 32'hDEAD_BEEF);

    // Unlisted offset inside the peripheral window.
    @(posedge clk_in); #1;
    ram_ce_in = 1'b1; ram_we_in = 1'b0; ram_addr_in = 32'h1000_0018;
    #1 chk("periph_0x18_rdata", {32'h0, ram_rdata_out}, 64'h0);
    chk("bad_before_0x18_edge", {63'h0, bad_access_out}, 64'h0);
    @(posedge clk_in); #1;
    ram_ce_in = 1'b0;
    chk("bad_after_0x18", {63'h0, bad_access_out}, 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/dbus_slave.md
# dbus_slave

Responder for the core's data-bus port (ram_ce/ram_we/ram_addr/ram_wdata → ram_rdata). It decodes each access to a word-addressed data RAM or a small memory-mapped peripheral window: a 64-bit machine timer with compare interrupt, and a tohost/halt register for ISA tests. It sits on the bus opposite core_top's mem stage. It answers reads in the same cycle, because the mem stage consumes read data combinationally, and commits writes on the clock edge.

## Interface
- RAM_DEPTH, 1024: data RAM depth in 32-bit words; power of two.
- PERIPH_BASE, 32'h1000_0000: base of the peripheral window. addr[31:28] selects the region.
- clk_in  input  1  core clock; all state updates on rising edge.
- reset_in  input  1  asynchronous, active-low reset.
- ram_ce_in  input  1  access valid this cycle.
- ram_we_in  input  1  1 = write, 0 = read; qualified by ram_ce_in.
- ram_addr_in  input  ADDR_WIDTH(32)  byte address; bits [1:0] ignored.
- ram_wdata_in  input  DATA_WIDTH(32)  write data, full word.
- ram_rdata_out  output  DATA_WIDTH(32)  read data, combinational.
- timer_irq_out  output  1  registered timer interrupt level.
- halt_out  output  1  sticky; set by the first nonzero tohost write.
- bad_access_out  output  1  sticky; set by any access to an unmapped address.

## Operation
- Region decode:
  - addr[31:28]==4'h0: RAM. Word index is addr[log2(RAM_DEPTH)+1:2]; higher bits are ignored, so accesses alias modulo the depth.
  - addr[31:28]==PERIPH_BASE[31:28] with offset addr[7:0] in the register map below: peripheral.
  - Anything else is unmapped: reads return 0, writes are dropped, and bad_access_out is set.
- Peripheral map (word offsets, all RW unless noted):
  - 0x00 MTIME_LO, 0x04 MTIME_HI.
  - 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI.
  - 0x10 CTRL: bit0 timer enable; other bits read 0.
  - 0x14 TOHOST: write-once nonzero, then read-only.
  - Unlisted offsets inside the window count as unmapped.
- Reads: ram_rdata_out = selected word when ram_ce_in=1 and ram_we_in=0, else 32'h0.
- Writes: ram_ce_in=1 and ram_we_in=1 commits at the rising edge. Full word only; sub-word merging is done in the core mem stage.
- Timer:
  - When CTRL[0]=1, mtime increments by 1 per cycle and wraps from 64'hFFFF_FFFF_FFFF_FFFF to 0.
  - A write to MTIME_LO or MTIME_HI loads that half. In that cycle the other half holds and no increment occurs.
- Interrupt: timer_irq_out <= CTRL[0] && (mtime >= mtimecmp), a 64-bit unsigned compare of current register values, registered. It is cleared only by rewriting MTIMECMP or MTIME, or by disabling the timer.
- TOHOST:
  - If TOHOST==0 and wdata!=0, latch wdata and set halt_out.
  - Once TOHOST is nonzero, further writes are ignored.
  - Writes of 0 while TOHOST==0 are ignored.
- Reset (reset_in low, asynchronous):
  - Registers: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, CTRL=0, TOHOST=0.
  - Outputs: timer_irq_out=0, halt_out=0, bad_access_out=0; ram_rdata_out=0 while ce is low.
  - RAM contents are not reset.
- Reset asserted mid-write: the write is lost; no partial update.

## Timing
- Read latency: 0 cycles (combinational from ram_ce_in/ram_addr_in/register state).
- Write: visible to a read in the following cycle. A same-cycle read of the target address returns the old value.
- MTIME read returns the pre-increment value of the current cycle.
- timer_irq_out rises 1 cycle after the edge where mtime reaches mtimecmp.
- halt_out and bad_access_out rise at the edge of the offending write/access and stay high until reset.
- No back-pressure: every access completes in one cycle; no stall output.

## Structure
- Shared package dbus_pkg holds the following, for reuse by the SoC bus decoder and testbenches:
  - region tag constants (RAM, PERIPH, NONE);
  - peripheral offset localparams (OFF_MTIME_LO … OFF_TOHOST);
  - the CTRL bit index.
- Sub-module mtimer: the 64-bit mtime/mtimecmp registers, load ports, increment, compare and irq register.
- dbus_slave contains the decode, the RAM array, TOHOST/halt, the bad-access flag and the read mux.

## Test plan
- Write 32'hDEAD_BEEF to 0x0000_0040, then read 0x0000_0040 → 32'hDEAD_BEEF. Read 0x0000_1040 with RAM_DEPTH=1024 → same value (alias).
- MTIMECMP=10, CTRL=1 from mtime=0 → timer_irq_out goes high on the 11th edge after enable; writing MTIMECMP_LO=100 → irq low next cycle.
- MTIME_LO=32'hFFFF_FFFF, MTIME_HI=32'hFFFF_FFFF, enable → after 1 cycle MTIME reads 0/0.
- Write 1 to TOHOST → halt_out=1 next cycle, TOHOST reads 1; then write 5 → TOHOST still 1.
- Read 0x2000_0000 → rdata 0 and bad_access_out=1; read offset 0x18 in the peripheral window → also flagged.
- Pulse reset_in low mid-run with the timer enabled and halt set → all outputs 0 and mtime 0 immediately, without waiting for a clock edge.
